alu_unit: RTL and testbench
===========================

// Module: alu_unit
// PURPOSE
//  32-bit registered-input ALU: 15 arithmetic/logic ops selected by a 4-bit opcode, plus status flags.
//  Operands and opcode are captured on CLOCK; result and flags are combinational from the captured values.
//  Sits in the datapath functional unit between operand/opcode sources and the result bus.
// PARAMETERS
//  none (datapath width fixed at 32, opcode width fixed at 4)
// PORTS
//  CLOCK   in   1   single clock; all state updates on rising edge
//  RESET   in   1   reset, synchronous, active-high
//  A       in   32  operand A (two's complement)
//  B       in   32  operand B (two's complement)
//  INST    in   4   opcode
//  Z       out  32  result
//  FLAGS   out  4   [0]=OVF, [1]=CARRY, [2]=ZERO, [3]=reserved (always 0)
// BEHAVIOUR
//  - Input regs a_r, b_r, inst_r load A, B, INST every rising edge; no enable, no stall.
//  - RESET (sampled at edge) has priority: a_r=0, b_r=0, inst_r=4'h2 -> Z=0, FLAGS=4'b0100.
//  - Latency: Z/FLAGS reflect inputs sampled at edge N, valid after edge N; stable through edge N+1.
//  - Z, FLAGS are purely combinational from a_r/b_r/inst_r; no output register.
//  - Opcodes (results mod 2^32):
//    0 A+1 | 1 A-1 | 2 A+B | 3 A-B | 4 abs(A) | 5 -A | 6 reserved: Z=0 | 7 -B
//    8 A&B | 9 A|B | A A^B | B ~B | C A | D ~A | E 0 | F 32'hFFFFFFFF
//  - Arithmetic uses one 32-bit adder X+Y+cin:
//    0: A+0+1; 1: A+FFFFFFFF+0; 2: A+B+0; 3: A+~B+1; 5: 0+~A+1; 7: 0+~B+1;
//    4: A[31]=1 -> 0+~A+1, else A+0+0.
//  - CARRY = adder carry-out of bit 31 for ops 0-5,7; 0 for all other ops.
//  - OVF = signed overflow (X[31]==Y[31] && Z[31]!=X[31]) for ops 0-5,7; 0 otherwise.
//    Hence abs/neg of 32'h80000000 -> Z=32'h80000000, OVF=1.
//  - ZERO = (Z==0) for every opcode, including 6 and E.
//  - FLAGS[3] always 0. No X propagation on any opcode value.
// TESTING
//  1. RESET=1 one edge -> Z=0, FLAGS=4'b0100; deassert, A=5,B=3,INST=2 -> next cycle Z=8, FLAGS=0.
//  2. INST=0, A=32'h7FFFFFFF -> Z=32'h80000000, OVF=1, CARRY=0; A=32'hFFFFFFFF -> Z=0, CARRY=1, ZERO=1.
//  3. INST=3, A=B=32'h12345678 -> Z=0, CARRY=1, ZERO=1; A=0,B=1 -> Z=32'hFFFFFFFF, CARRY=0.
//  4. INST=4, A=32'hFFFFFFF6 -> Z=10; A=32'h80000000 -> Z=32'h80000000, OVF=1.
//  5. Random A/B, sweep INST 0..F back-to-back each cycle -> Z matches op table one cycle later; ZERO==(Z==0).
//  6. INST=6 any A/B -> Z=0, FLAGS=4'b0100; INST=F -> Z=32'hFFFFFFFF, FLAGS=0.

Source files
------------

// File: rtl/alu_unit_if.sv
// alu_unit_if: operand/opcode and result/flags bundle for the ALU
interface alu_unit_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  INST;
    logic [31:0] Z;
    logic [3:0]  FLAGS;

    modport master (output A, output B, output INST, input Z, input FLAGS);
    modport slave  (input A, input B, input INST, output Z, output FLAGS);
endinterface

// File: rtl/alu_unit.sv
// alu_unit: 32-bit registered-input ALU with 16 opcodes and OVF/CARRY/ZERO flags
module alu_unit (
    input logic       CLOCK,
    input logic       RESET,
    alu_unit_if.slave bus
);
    logic [31:0] a_q, b_q, a_d, b_d;
    logic [3:0]  inst_q, inst_d;
    logic [31:0] x, y, z;
    logic        cin, arith;
    logic [32:0] sum;

    // next-state for the input registers: reset loads the A+B opcode with zero operands
    always_comb begin
        a_d    = RESET ? 32'h0 : bus.A;
        b_d    = RESET ? 32'h0 : bus.B;
        inst_d = RESET ? 4'h2 : bus.INST;
    end

    // capture operands and opcode every rising edge
    always_ff @(posedge CLOCK) begin
        a_q    <= a_d;
        b_q    <= b_d;
        inst_q <= inst_d;
    end

    // route operands into the single shared adder; logic ops bypass it
    always_comb begin
        x     = 32'h0;
        y     = 32'h0;
        cin   = 1'b0;
        arith = 1'b1;
        case (inst_q)
            4'h0: begin x = a_q; cin = 1'b1; end
            4'h1: begin x = a_q; y = 32'hFFFF_FFFF; end
            4'h2: begin x = a_q; y = b_q; end
            4'h3: begin x = a_q; y = ~b_q; cin = 1'b1; end
            4'h4: begin x = a_q[31] ? 32'h0 : a_q; y = a_q[31] ? ~a_q : 32'h0; cin = a_q[31]; end
            4'h5: begin y = ~a_q; cin = 1'b1; end
            4'h7: begin y = ~b_q; cin = 1'b1; end
            default: arith = 1'b0;
        endcase
        sum = {1'b0, x} + {1'b0, y} + {32'h0, cin};
    end

    // select the result and derive flags from the captured operands
    always_comb begin
        case (inst_q)
            4'h8:    z = a_q & b_q;
            4'h9:    z = a_q | b_q;
            4'hA:    z = a_q ^ b_q;
            4'hB:    z = ~b_q;
            4'hC:    z = a_q;
            4'hD:    z = ~a_q;
            4'hF:    z = 32'hFFFF_FFFF;
            default: z = arith ? sum[31:0] : 32'h0;
        endcase
        bus.Z        = z;
        bus.FLAGS[0] = arith & (x[31] == y[31]) & (z[31] != x[31]);
        bus.FLAGS[1] = arith & sum[32];
        bus.FLAGS[2] = (z == 32'h0);
        bus.FLAGS[3] = 1'b0;
    end
endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: table-driven and randomized self-checking bench for alu_unit
module tb_alu_unit;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int errors = 0;
    int checks = 0;

    alu_unit_if bus ();
    alu_unit dut (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));

    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] z;
        logic [3:0]  f;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [35:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        logic [31:0] z;
        logic [32:0] w;
        logic c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'h0: begin z = a + 1; c = (a == 32'hFFFF_FFFF); v = (a == 32'h7FFF_FFFF); end
            4'h1: begin z = a - 1; c = (a != 0); v = (a == 32'h8000_0000); end
            4'h2: begin w = {1'b0, a} + {1'b0, b}; z = w[31:0]; c = w[32]; v = (a[31] == b[31]) && (z[31] != a[31]); end
            4'h3: begin z = a - b; c = (a >= b); v = (a[31] != b[31]) && (z[31] != a[31]); end
            4'h4: begin z = a[31] ? -a : a; v = (a == 32'h8000_0000); end
            4'h5: begin z = -a; c = (a == 0); v = (a == 32'h8000_0000); end
            4'h7: begin z = -b; c = (b == 0); v = (b == 32'h8000_0000); end
            4'h8: z = a & b;
            4'h9: z = a | b;
            4'hA: z = a ^ b;
            4'hB: z = ~b;
            4'hC: z = a;
            4'hD: z = ~a;
            4'hF: z = 32'hFFFF_FFFF;
            default: z = 32'h0;
        endcase
        return {1'b0, z == 0, c, v, z};
    endfunction

    task automatic chk(string name, logic [31:0] ze, logic [3:0] fe);
        checks++;
        if (bus.Z !== ze || bus.FLAGS !== fe) begin
            errors++;
            $display("FAIL %s: Z=%h FLAGS=%b, required Z=%h FLAGS=%b", name, bus.Z, bus.FLAGS, ze, fe);
        end
    endtask

    task automatic apply(logic [31:0] a, logic [31:0] b, logic [3:0] op);
        bus.A = a;
        bus.B = b;
        bus.INST = op;
        @(posedge CLOCK);
        #1;
    endtask

    initial begin
        logic [35:0] r;
        logic [31:0] ra, rb;
        tbl[0]  = '{32'h7FFF_FFFF, 32'h0,         4'h0, 32'h8000_0000, 4'b0001};
        tbl[1]  = '{32'hFFFF_FFFF, 32'h0,         4'h0, 32'h0,         4'b0110};
        tbl[2]  = '{32'h1234_5678, 32'h1234_5678, 4'h3, 32'h0,         4'b0110};
        tbl[3]  = '{32'h0,         32'h1,         4'h3, 32'hFFFF_FFFF, 4'b0000};
        tbl[4]  = '{32'hFFFF_FFF6, 32'h0,         4'h4, 32'd10,        4'b0000};
        tbl[5]  = '{32'h8000_0000, 32'h0,         4'h4, 32'h8000_0000, 4'b0001};
        tbl[6]  = '{32'h0000_1234, 32'h0000_5678, 4'h6, 32'h0,         4'b0100};
        tbl[7]  = '{32'h0000_1234, 32'h0000_5678, 4'hF, 32'hFFFF_FFFF, 4'b0000};
        tbl[8]  = '{32'h0,         32'h0,         4'h1, 32'hFFFF_FFFF, 4'b0000};
        tbl[9]  = '{32'h8000_0000, 32'h0,         4'h1, 32'h7FFF_FFFF, 4'b0011};
        tbl[10] = '{32'h0,         32'h0,         4'h5, 32'h0,         4'b0110};
        tbl[11] = '{32'h0,         32'h8000_0000, 4'h7, 32'h8000_0000, 4'b0001};
        tbl[12] = '{32'hDEAD_BEEF, 32'h1,         4'hE, 32'h0,         4'b0100};
        tbl[13] = '{32'hF0F0_F0F0, 32'h0F0F_0F0F, 4'h8, 32'h0,         4'b0100};
        tbl[14] = '{32'hFFFF_FFFF, 32'h1,         4'h2, 32'h0,         4'b0110};

        // reset wins over live inputs
        RESET = 1'b1;
        apply(32'hFFFF_FFFF, 32'h1234_5678, 4'hF);
        chk("reset", 32'h0, 4'b0100);
        RESET = 1'b0;
        apply(32'd5, 32'd3, 4'h2);
        chk("add_after_reset", 32'd8, 4'b0000);

        // outputs hold between edges even as inputs move
        bus.A = 32'h1;
        bus.B = 32'h1;
        bus.INST = 4'hF;
        #3;
        chk("hold_between_edges", 32'd8, 4'b0000);

        for (int i = 0; i < 15; i++) begin
            apply(tbl[i].a, tbl[i].b, tbl[i].op);
            chk($sformatf("table[%0d]", i), tbl[i].z, tbl[i].f);
        end

        // reset mid-stream
        RESET = 1'b1;
        apply(32'h7, 32'h9, 4'h9);
        chk("reset_midstream", 32'h0, 4'b0100);
        RESET = 1'b0;

        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: rb = 32'h8000_0000;
                2: ra = 32'h0;
                3: rb = ra;
                default: ;
            endcase
            apply(ra, rb, 4'(i));
            r = ref_alu(ra, rb, 4'(i));
            chk($sformatf("rand[%0d] op=%h a=%h b=%h", i, 4'(i), ra, rb), r[31:0], r[35:32]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
